// File: rtl/piece_spawner_pkg.sv
// Shared tetromino definitions: piece indices, shapes, board coordinates and
// the spawn-pose helper used by the piece spawner.
package piece_spawner_pkg;

  localparam int NUMBER_OF_TETROMINO = 7;
  localparam int COORD_W             = 6;

  typedef logic [2:0]                tetromino_idx_t;
  typedef logic [15:0]               tetromino_t;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } coordinate_t;

  typedef struct packed {
    tetromino_idx_t idx;
    tetromino_t     tetromino;
    logic [1:0]     rotation;
    coordinate_t    coordinate;
  } tetromino_ctrl;

  localparam tetromino_idx_t TETROMINO_I_IDX = 3'd0;
  localparam tetromino_idx_t TETROMINO_O_IDX = 3'd1;
  localparam tetromino_idx_t TETROMINO_T_IDX = 3'd2;
  localparam tetromino_idx_t TETROMINO_S_IDX = 3'd3;
  localparam tetromino_idx_t TETROMINO_Z_IDX = 3'd4;
  localparam tetromino_idx_t TETROMINO_J_IDX = 3'd5;
  localparam tetromino_idx_t TETROMINO_L_IDX = 3'd6;

  localparam coord_t SPAWN_X = 6'sd3;

  // The I piece occupies row 1 of its box, so it enters one row lower than the rest.
  function automatic tetromino_ctrl spawn_pose(input tetromino_idx_t idx, input tetromino_t shape);
    tetromino_ctrl c;
    c.idx          = idx;
    c.tetromino    = shape;
    c.rotation     = 2'd0;
    c.coordinate.x = SPAWN_X;
    c.coordinate.y = (idx == TETROMINO_I_IDX) ? 6'sd0 : -6'sd1;
    return c;
  endfunction

endpackage

// File: rtl/piece_spawner_get_tetromino_info.sv
// Rotation-0 shape lookup: 4x4 bitmap, row 0 in bits [15:12], column 0 is the MSB of each row.
module get_tetromino_info
  import piece_spawner_pkg::*;
(
  input  tetromino_idx_t idx_i,
  output tetromino_t     shape_o
);

  // Shape table
  always_comb begin
    shape_o = 16'h0000;
    case (idx_i)
      TETROMINO_I_IDX: shape_o = 16'h0F00;
      TETROMINO_O_IDX: shape_o = 16'h6600;
      TETROMINO_T_IDX: shape_o = 16'h4E00;
      TETROMINO_S_IDX: shape_o = 16'h6C00;
      TETROMINO_Z_IDX: shape_o = 16'hC600;
      TETROMINO_J_IDX: shape_o = 16'h8E00;
      TETROMINO_L_IDX: shape_o = 16'h2E00;
      default:         shape_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/piece_spawner.sv
// Piece spawner: fills a shift-register preview queue from the generator, then
// serves spawn requests and the once-per-piece hold/swap slot.
module piece_spawner
  import piece_spawner_pkg::*;
#(
  parameter int PREVIEW_DEPTH = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  tetromino_ctrl                        gen_next,
  output logic                                 gen_enable,
  input  logic                                 spawn_req,
  input  logic                                 hold_req,
  output tetromino_ctrl                        spawn,
  output logic                                 spawn_valid,
  output tetromino_idx_t [PREVIEW_DEPTH-1:0]   preview,
  output tetromino_idx_t                       hold_idx,
  output logic                                 hold_valid,
  output logic                                 hold_locked,
  output logic                                 busy
);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam int         CNT_W    = $clog2(PREVIEW_DEPTH + 1);

  logic [0:0]                        state_q, state_d;
  logic [CNT_W-1:0]                  fill_cnt_q, fill_cnt_d;
  tetromino_idx_t [PREVIEW_DEPTH-1:0] queue_q, queue_d;
  tetromino_ctrl                     spawn_q, spawn_d;
  logic                              spawn_valid_q, spawn_valid_d;
  tetromino_idx_t                    hold_idx_q, hold_idx_d;
  logic                              hold_valid_q, hold_valid_d;
  logic                              hold_locked_q, hold_locked_d;
  logic                              spawned_q, spawned_d;

  logic           fill_s, hold_ok_s, swap_s, take_s, shift_s;
  tetromino_idx_t next_idx_s;
  tetromino_t     shape_s;
  logic           unused_gen_s;

  // A spawn request always beats a hold request in the same cycle.
  assign fill_s     = (state_q == ST_FILL);
  assign hold_ok_s  = (state_q == ST_READY) && !spawn_req && hold_req && !hold_locked_q && spawned_q;
  assign swap_s     = hold_ok_s && hold_valid_q;
  assign take_s     = (state_q == ST_READY) && (spawn_req || (hold_ok_s && !hold_valid_q));
  assign shift_s    = fill_s || take_s;
  assign next_idx_s = swap_s ? hold_idx_q : queue_q[0];
  assign gen_enable = rst_n && shift_s;

  assign unused_gen_s = ^{gen_next.tetromino, gen_next.rotation, gen_next.coordinate};

  get_tetromino_info u_info (
    .idx_i   (next_idx_s),
    .shape_o (shape_s)
  );

  // Next-state logic for the queue, hold slot, spawn descriptor and FSM
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    queue_d       = queue_q;
    spawn_d       = spawn_q;
    spawn_valid_d = 1'b0;
    hold_idx_d    = hold_idx_q;
    hold_valid_d  = hold_valid_q;
    hold_locked_d = hold_locked_q;
    spawned_d     = spawned_q;

    if (shift_s) begin
      for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
        queue_d[i] = queue_q[i+1];
      end
      queue_d[PREVIEW_DEPTH-1] = gen_next.idx;
    end else begin
      queue_d = queue_q;
    end

    case (state_q)
      ST_FILL: begin
        fill_cnt_d = fill_cnt_q + CNT_W'(1);
        if (fill_cnt_d == CNT_W'(PREVIEW_DEPTH)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_READY: begin
        if (take_s || swap_s) begin
          spawn_d       = spawn_pose(next_idx_s, shape_s);
          spawn_valid_d = 1'b1;
          spawned_d     = 1'b1;
        end else begin
          spawn_d = spawn_q;
        end
        if (spawn_req) begin
          hold_locked_d = 1'b0;
        end else if (hold_ok_s) begin
          hold_idx_d    = spawn_q.idx;
          hold_valid_d  = 1'b1;
          hold_locked_d = 1'b1;
        end else begin
          hold_locked_d = hold_locked_q;
        end
      end
      default: begin
        state_d    = ST_FILL;
        fill_cnt_d = '0;
      end
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      fill_cnt_q    <= '0;
      queue_q       <= '0;
      spawn_q       <= '0;
      spawn_valid_q <= 1'b0;
      hold_idx_q    <= 3'd0;
      hold_valid_q  <= 1'b0;
      hold_locked_q <= 1'b0;
      spawned_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      queue_q       <= queue_d;
      spawn_q       <= spawn_d;
      spawn_valid_q <= spawn_valid_d;
      hold_idx_q    <= hold_idx_d;
      hold_valid_q  <= hold_valid_d;
      hold_locked_q <= hold_locked_d;
      spawned_q     <= spawned_d;
    end
  end

  assign spawn       = spawn_q;
  assign spawn_valid = spawn_valid_q;
  assign preview     = queue_q;
  assign hold_idx    = hold_idx_q;
  assign hold_valid  = hold_valid_q;
  assign hold_locked = hold_locked_q;
  assign busy        = fill_s;

endmodule

// File: tb/tb_piece_spawner.sv
// Self-checking bench for piece_spawner: directed vector table, randomized traffic
// against a queue-based reference model, and an asynchronous mid-run reset.
module tb_piece_spawner;
  import piece_spawner_pkg::*;

  localparam int D = 3;

  logic                       clk = 1'b0;
  logic                       rst_n;
  tetromino_ctrl              gen_next;
  logic                       gen_enable;
  logic                       spawn_req;
  logic                       hold_req;
  tetromino_ctrl              spawn;
  logic                       spawn_valid;
  tetromino_idx_t [D-1:0]     preview;
  tetromino_idx_t             hold_idx;
  logic                       hold_valid;
  logic                       hold_locked;
  logic                       busy;

  piece_spawner #(.PREVIEW_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gen_next    (gen_next),
    .gen_enable  (gen_enable),
    .spawn_req   (spawn_req),
    .hold_req    (hold_req),
    .spawn       (spawn),
    .spawn_valid (spawn_valid),
    .preview     (preview),
    .hold_idx    (hold_idx),
    .hold_valid  (hold_valid),
    .hold_locked (hold_locked),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] shapes [0:6];

  // Reference model state: the preview is just a queue of upcoming indices.
  tetromino_idx_t mq[$];
  int             m_fill;
  bit             m_filling, m_hv, m_hl, m_spawned, m_sv;
  tetromino_idx_t m_hidx;
  tetromino_ctrl  m_spawn;
  bit             gen_seen;

  typedef struct {
    bit             sr;
    bit             hr;
    tetromino_idx_t g;
    bit             gen;
    bit             busy;
    bit             sv;
    tetromino_idx_t sidx;
    bit             hv;
    tetromino_idx_t hidx;
    bit             hl;
    logic [3*D-1:0] prev;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tetromino_ctrl mk(input tetromino_idx_t i);
    tetromino_ctrl c;
    c              = '0;
    c.idx          = i;
    c.tetromino    = shapes[i];
    c.rotation     = 2'd0;
    c.coordinate.x = 6'sd3;
    c.coordinate.y = (i == TETROMINO_I_IDX) ? 6'sd0 : -6'sd1;
    return c;
  endfunction

  function automatic logic [3*D-1:0] pv(input int e0, input int e1, input int e2);
    logic [2:0] a, b, c;
    a = 3'(e0);
    b = 3'(e1);
    c = 3'(e2);
    return {c, b, a};
  endfunction

  function automatic logic [3*D-1:0] model_preview();
    logic [3*D-1:0] p;
    p = '0;
    for (int i = 0; i < D; i++) p[3*i +: 3] = mq[i];
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < D; i++) mq.push_back(3'd0);
    m_fill    = 0;
    m_filling = 1'b1;
    m_hv      = 1'b0;
    m_hl      = 1'b0;
    m_spawned = 1'b0;
    m_hidx    = 3'd0;
    m_spawn   = '0;
    m_sv      = 1'b0;
  endtask

  task automatic model_take(input tetromino_idx_t g);
    tetromino_idx_t p;
    p = mq.pop_front();
    mq.push_back(g);
    m_spawn   = mk(p);
    m_sv      = 1'b1;
    m_spawned = 1'b1;
  endtask

  task automatic model_step(input bit sr, input bit hr, input tetromino_idx_t g, output bit gen);
    tetromino_idx_t t;
    m_sv = 1'b0;
    gen  = 1'b0;
    if (m_filling) begin
      t = mq.pop_front();
      mq.push_back(g);
      m_fill++;
      gen = 1'b1;
      if (m_fill == D) m_filling = 1'b0;
    end else if (sr) begin
      model_take(g);
      gen  = 1'b1;
      m_hl = 1'b0;
    end else if (hr && !m_hl && m_spawned) begin
      if (!m_hv) begin
        m_hidx = m_spawn.idx;
        m_hv   = 1'b1;
        model_take(g);
        gen = 1'b1;
      end else begin
        t       = m_hidx;
        m_hidx  = m_spawn.idx;
        m_spawn = mk(t);
        m_sv    = 1'b1;
      end
      m_hl = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("busy",        busy,        m_filling);
    chk("spawn_valid", spawn_valid, m_sv);
    chk("spawn",       spawn,       m_spawn);
    chk("preview",     preview,     model_preview());
    chk("hold_idx",    hold_idx,    m_hidx);
    chk("hold_valid",  hold_valid,  m_hv);
    chk("hold_locked", hold_locked, m_hl);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit sr, input bit hr, input tetromino_idx_t g);
    bit eg;
    spawn_req          = sr;
    hold_req           = hr;
    gen_next.idx       = g;
    gen_next.tetromino = 16'($urandom);
    gen_next.rotation  = 2'($urandom);
    model_step(sr, hr, g, eg);
    #1;
    gen_seen = gen_enable;
    chk("gen_enable", gen_enable, eg);
    @(posedge clk);
    #1;
    check_all();
    spawn_req = 1'b0;
    hold_req  = 1'b0;
  endtask

  initial begin
    bit             r_sr, r_hr;
    tetromino_idx_t r_g;

    shapes[0] = 16'h0F00; shapes[1] = 16'h6600; shapes[2] = 16'h4E00; shapes[3] = 16'h6C00;
    shapes[4] = 16'hC600; shapes[5] = 16'h8E00; shapes[6] = 16'h2E00;

    //            sr    hr    g     gen   busy  sv    sidx  hv    hidx  hl    preview[0..2]
    tbl[0]  = '{1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, pv(0, 0, 2)};
    tbl[1]  = '{1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, pv(0, 2, 5)};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, pv(2, 5, 0)};
    tbl[3]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, pv(2, 5, 0)};
    tbl[4]  = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, pv(5, 0, 4)};
    tbl[5]  = '{1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 3'd2, 1'b1, pv(0, 4, 6)};
    tbl[6]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd2, 1'b1, pv(0, 4, 6)};
    tbl[7]  = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 3'd2, 1'b0, pv(4, 6, 1)};
    tbl[8]  = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd0, 1'b1, pv(4, 6, 1)};
    tbl[9]  = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, pv(6, 1, 3)};
    tbl[10] = '{1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 3'd0, 1'b0, pv(6, 1, 3)};

    rst_n     = 1'b0;
    spawn_req = 1'b0;
    hold_req  = 1'b0;
    gen_next  = '0;
    gen_seen  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("gen_enable_in_reset", gen_enable, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].sr, tbl[i].hr, tbl[i].g);
      chk($sformatf("tbl%0d_gen", i),   gen_seen,    tbl[i].gen);
      chk($sformatf("tbl%0d_busy", i),  busy,        tbl[i].busy);
      chk($sformatf("tbl%0d_sv", i),    spawn_valid, tbl[i].sv);
      chk($sformatf("tbl%0d_sidx", i),  spawn.idx,   tbl[i].sidx);
      chk($sformatf("tbl%0d_hv", i),    hold_valid,  tbl[i].hv);
      chk($sformatf("tbl%0d_hidx", i),  hold_idx,    tbl[i].hidx);
      chk($sformatf("tbl%0d_hl", i),    hold_locked, tbl[i].hl);
      chk($sformatf("tbl%0d_prev", i),  preview,     tbl[i].prev);
      if (tbl[i].sv) chk($sformatf("tbl%0d_spawn", i), spawn, mk(tbl[i].sidx));
    end

    for (int i = 0; i < 400; i++) begin
      r_sr = ($urandom_range(9, 0) < 3);
      r_hr = ($urandom_range(9, 0) < 3);
      r_g  = 3'($urandom_range(6, 0));
      step(r_sr, r_hr, r_g);
    end

    // Guarantee a populated hold slot, then reset in the middle of a cycle.
    step(1'b1, 1'b0, 3'd1);
    step(1'b0, 1'b1, 3'd6);
    chk("hold_before_reset", hold_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("gen_enable_mid_reset", gen_enable, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'($urandom_range(6, 0)));
    chk("busy_after_refill", busy, 1'b0);
    chk("hold_after_refill", hold_valid, 1'b0);

    for (int i = 0; i < 200; i++) begin
      r_sr = ($urandom_range(9, 0) < 3);
      r_hr = ($urandom_range(9, 0) < 4);
      r_g  = 3'($urandom_range(6, 0));
      step(r_sr, r_hr, r_g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
